mmio_arbiter: RTL and testbench

Shares the single MMIO bus (the bus `mmio_top` decodes into slots) between `N_REQ` bus masters, e.g. the MCS I/O bridge and an on-chip sequencer that streams samples to the audio slot. Each requester holds a valid/ready-style request. The arbiter grants one requester at a time in round-robin order and replays its access as a one-cycle MMIO strobe. It then returns read data together with a one-cycle acknowledge.

---
 rtl/mmio_pkg.sv | 6 +
 rtl/rr_picker.sv | 21 ++
 rtl/mmio_arbiter.sv | 86 ++++++++
 tb/tb_mmio_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO bus widths and arbiter state encoding
package mmio_pkg;
  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector, search starts just after the last grant
module rr_picker #(
  parameter int N_REQ = 2,
  localparam int LW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic             valid,
  output logic [LW-1:0]    idx
);
  logic [N_REQ-1:0] w_hi;
  assign valid = |req;
  // lowest requester above last wins; otherwise wrap to the lowest requester overall
  always_comb begin
    w_hi = '0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) w_hi[i] = req[i] && (i > int'(last));
    for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) idx = LW'(i);
    for (int i = N_REQ - 1; i >= 0; i--) if (w_hi[i]) idx = LW'(i);
  end
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: round-robin sharing of the MMIO bus with a one-cycle strobe and one-cycle ack
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_req_write,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  i_req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  i_req_wdata,
  output logic [N_REQ-1:0]              o_req_ack,
  output logic [DATA_W-1:0]             o_req_rdata,
  output logic                          o_mmio_cs,
  output logic                          o_mmio_write,
  output logic                          o_mmio_read,
  output logic [ADDR_W-1:0]             o_mmio_addr,
  output logic [DATA_W-1:0]             o_mmio_write_data,
  input  logic [DATA_W-1:0]             i_mmio_read_data
);
  localparam int LW = $clog2(N_REQ);
  arb_state_t r_state, w_next;
  logic [LW-1:0] r_grant, r_last, w_idx;
  logic w_valid, w_issue, w_cs, w_write, w_read;
  logic [N_REQ-1:0] w_ack, r_ack;
  logic r_write, r_cs, r_wr, r_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req(i_req), .last(r_last), .valid(w_valid), .idx(w_idx)
  );
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_valid ? ISSUE : IDLE) : r_state == ISSUE ? ACK : IDLE;
  end
  // strobes and ack are computed one cycle early so every output comes straight from a flop
  always_comb begin
    w_issue = (r_state == IDLE) && w_valid;
    w_cs = w_issue;
    w_write = w_issue && i_req_write[w_idx];
    w_read = w_issue && !i_req_write[w_idx];
    w_ack = (r_state == ISSUE) ? N_REQ'(1) << r_grant : '0;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cs <= 1'b0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_ack <= '0;
      r_grant <= '0;
      r_last <= LW'(N_REQ - 1);
      r_write <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_cs <= w_cs;
      r_wr <= w_write;
      r_rd <= w_read;
      r_ack <= w_ack;
      if (w_issue) begin
        r_grant <= w_idx;
        r_write <= i_req_write[w_idx];
        r_addr <= i_req_addr[w_idx];
        r_wdata <= i_req_wdata[w_idx];
      end
      if (r_state == ISSUE) begin
        r_last <= r_grant;
        r_rdata <= r_write ? '0 : i_mmio_read_data;
      end else r_rdata <= '0;
    end
  end
  assign o_req_ack = r_ack;
  assign o_req_rdata = r_rdata;
  assign o_mmio_cs = r_cs;
  assign o_mmio_write = r_wr;
  assign o_mmio_read = r_rd;
  assign o_mmio_addr = r_addr;
  assign o_mmio_write_data = r_wdata;
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed stimulus checked against a transaction-schedule model of the arbiter
module tb_mmio_arbiter;
  localparam int N = 2;
  logic clk, rst_n;
  logic [N-1:0] req, req_wr, ack;
  logic [N-1:0][20:0] req_addr;
  logic [N-1:0][31:0] req_wd;
  logic [31:0] rdata, wdata, rd_data;
  logic [20:0] addr;
  logic cs, wr, rd, rd_auto;
  int checks = 0, failures = 0;
  int acks[$];
  mmio_arbiter dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_write(req_wr),
    .i_req_addr(req_addr), .i_req_wdata(req_wd), .o_req_ack(ack), .o_req_rdata(rdata),
    .o_mmio_cs(cs), .o_mmio_write(wr), .o_mmio_read(rd), .o_mmio_addr(addr),
    .o_mmio_write_data(wdata), .i_mmio_read_data(rd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rd_auto) rd_data = rd_data + 32'h01010101;
    end
  endtask
  // model: a grant at the end of cycle c schedules strobe at c+1, ack at c+2, next grant no earlier than c+3
  int cyc, nxt_free, stb_at, ack_at, m_last, m_win;
  logic m_wr;
  logic [20:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; nxt_free = 0; stb_at = -1; ack_at = -1; m_last = N - 1; m_win = 0; m_rdata = 0;
    end else begin
      if (cyc == stb_at) m_rdata = m_wr ? 32'h0 : rd_data;
      if (cyc >= nxt_free && |req) begin
        for (int k = N; k >= 1; k--) if (req[(m_last + k) % N]) m_win = (m_last + k) % N;
        m_last = m_win;
        m_wr = req_wr[m_win];
        m_addr = req_addr[m_win];
        m_wdata = req_wd[m_win];
        stb_at = cyc + 1; ack_at = cyc + 2; nxt_free = cyc + 3;
      end
      cyc++;
    end
  end
  logic prev_cs = 0;
  always @(negedge clk) begin
    logic e_cs;
    logic [N-1:0] e_ack;
    e_cs = (cyc == stb_at);
    e_ack = (cyc == ack_at) ? N'(1) << m_win : '0;
    chk("cs", cs, e_cs);
    chk("write", wr, e_cs && m_wr);
    chk("read", rd, e_cs && !m_wr);
    chk("ack", ack, e_ack);
    chk("cs_back_to_back", cs && prev_cs, 0);
    if (e_cs) begin
      chk("addr", addr, m_addr);
      chk("wdata", wdata, m_wdata);
    end
    if (cyc == ack_at) chk("rdata", rdata, m_rdata);
    for (int i = 0; i < N; i++) if (ack[i]) acks.push_back(i);
    prev_cs = cs;
  end
  initial begin
    clk = 0; rst_n = 1; req = 0; req_wr = 0; req_addr = '0; req_wd = '0; rd_data = 0; rd_auto = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_cs", cs, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    tick(2); rst_n = 1;
    tick(1);
    req_wr[0] = 0; req_addr[0] = 21'h41; rd_data = 32'hDEADBEEF; req[0] = 1;
    tick(1);
    chk("t1_cs", cs, 1); chk("t1_read", rd, 1); chk("t1_addr", addr, 21'h41);
    tick(1);
    chk("t1_ack", ack, 2'b01); chk("t1_rdata", rdata, 32'hDEADBEEF); chk("t1_cs_low", cs, 0);
    req[0] = 0;
    tick(1);
    chk("t1_ack_low", ack, 0);
    req_wr[1] = 1; req_addr[1] = 21'h102; req_wd[1] = 32'h12345678; req[1] = 1;
    tick(1);
    chk("t2_write", wr, 1); chk("t2_read", rd, 0); chk("t2_addr", addr, 21'h102);
    chk("t2_wdata", wdata, 32'h12345678); chk("t2_ack_early", ack, 0);
    tick(1);
    chk("t2_ack", ack, 2'b10); chk("t2_rdata", rdata, 0);
    req[1] = 0;
    tick(1);
    acks.delete();
    rd_auto = 1; req_wr = 0; req_addr[0] = 21'h10; req_addr[1] = 21'h20; req = 2'b11;
    tick(12);
    req = 0;
    tick(2);
    chk("t3_ack_count", acks.size(), 4);
    if (acks.size() == 4) for (int i = 0; i < 4; i++) chk("t3_order", acks[i], i % 2);
    rd_auto = 0;
    req_wr[0] = 0; req_addr[0] = 21'h55; req[0] = 1;
    tick(1);
    req_addr[0] = 21'h1FFFFF;
    chk("t4_orig_addr", addr, 21'h55);
    tick(1);
    chk("t4_ack", ack, 2'b01);
    tick(1);
    chk("t4_idle_cs", cs, 0);
    tick(1);
    chk("t4_new_cs", cs, 1); chk("t4_new_addr", addr, 21'h1FFFFF);
    tick(1);
    chk("t4_ack2", ack, 2'b01);
    req[0] = 0;
    tick(1);
    req_wr = 0; req_addr[0] = 21'h0A0; req_addr[1] = 21'h0B1; req[1] = 1;
    tick(1);
    chk("t5_pre_cs", cs, 1); chk("t5_pre_addr", addr, 21'h0B1);
    rst_n = 0; req[0] = 1;
    #1;
    chk("t5_rst_cs", cs, 0); chk("t5_rst_read", rd, 0); chk("t5_rst_ack", ack, 0); chk("t5_rst_addr", addr, 0);
    tick(2); rst_n = 1;
    tick(1);
    chk("t5_first_cs", cs, 1); chk("t5_first_addr", addr, 21'h0A0);
    tick(1);
    chk("t5_first_ack", ack, 2'b01);
    req[0] = 0;
    tick(2);
    chk("t5_second_addr", addr, 21'h0B1);
    tick(1);
    chk("t5_second_ack", ack, 2'b10);
    req[1] = 0;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
